tbu_lifo_reorder: RTL and testbench
===================================

// Module: tbu_lifo_reorder
// PURPOSE
//  Downstream of the traceback unit. The traceback unit emits decoded bits in
//  reverse time order as a d_o/wr_en stream. This block reverses each block of
//  BLOCK_LEN bits and presents them in forward order on a valid/ready port.
//  It uses two ping-pong LIFO banks, so one bank fills while the other drains.
// PARAMETERS
//  BLOCK_LEN  16  decoded bits per traceback block; must be >= 2
//  PTR_W      $clog2(BLOCK_LEN)  localparam, width of the bank pointers
// PORTS
//  clk       in   1  clock; all logic on rising edge
//  rst       in   1  reset, asynchronous, active-low
//  enable    in   1  synchronous run enable; 0 = clear block state (see below)
//  d_in      in   1  decoded bit from the traceback unit (its d_o)
//  wr_en     in   1  d_in is valid this cycle (traceback unit wr_en)
//  d_out     out  1  decoded bit, forward time order
//  d_valid   out  1  d_out is valid
//  d_ready   in   1  consumer accepts d_out this cycle
//  d_last    out  1  high with the final bit of each block (qualified by d_valid)
//  overflow  out  1  sticky: a write was dropped because no bank was free
// BEHAVIOUR
//  Reset (rst=0, async):
//   - d_out=0, d_valid=0, d_last=0, overflow=0.
//   - Both bank full flags=0, wr_ptr=0, rd_ptr=BLOCK_LEN-1, fill_bank=0, drain_bank=0.
//   - Storage contents are don't-care.
//  enable=0 (sync, priority over all else):
//   - Same clears as reset except storage.
//   - A partially filled block is discarded; a block being drained is abandoned.
//  Fill side (the writer cannot be stalled):
//   - Accept when wr_en=1 && enable=1 && full[fill_bank]==0.
//   - On accept: bank[fill_bank][wr_ptr] <= d_in.
//   - If wr_ptr==BLOCK_LEN-1: set full[fill_bank], toggle fill_bank, wr_ptr<=0.
//     Otherwise wr_ptr<=wr_ptr+1.
//   - If wr_en=1 and full[fill_bank]==1 (registered value at start of cycle):
//     drop the bit, set overflow=1, leave wr_ptr unchanged.
//   - A bank that frees in the same cycle is not writable until the next cycle.
//  Drain side:
//   - d_valid = full[drain_bank]; d_out = bank[drain_bank][rd_ptr].
//   - d_last = d_valid && (rd_ptr==0).
//   - Outputs depend on registers only; there is no combinational path from
//     d_in, wr_en or d_ready to any output.
//   - A transfer occurs when d_valid && d_ready.
//   - On a transfer with rd_ptr>0: rd_ptr<=rd_ptr-1.
//   - On a transfer with rd_ptr==0: clear full[drain_bank], toggle drain_bank,
//     rd_ptr<=BLOCK_LEN-1.
//   - While stalled (d_valid=1, d_ready=0), d_out and d_last hold stable.
//  Order: bits are read last-written-first, so the traceback's reversed stream
//   comes out in forward time order. Blocks leave in the order they were filled.
//  Latency: the edge that writes bit BLOCK_LEN-1 of a block into an idle drain
//   bank makes d_valid=1 on the following cycle, with that bit on d_out.
//   Sustained throughput is 1 bit/cycle.
//  Simultaneous events:
//   - Completing the fill of one bank and completing the drain of the other in
//     the same cycle are independent; both take effect.
//   - A full bank may not be refilled before it has drained.
//  Wrap: wr_ptr and rd_ptr never leave the range [0, BLOCK_LEN-1].
//  Overflow clears only on reset or enable=0.
// TESTING
//  1 BLOCK_LEN=8, d_ready=1, write 1,0,1,1,0,0,1,0
//    -> d_out 0,1,0,0,1,1,0,1; d_valid rises the cycle after the 8th write;
//       d_last on the 8th output.
//  2 Same block, d_ready=0 for 5 cycles after the 3rd output
//    -> d_out/d_valid held; all 8 bits delivered; overflow=0.
//  3 Three back-to-back blocks, d_ready=0
//    -> blocks 1 and 2 stored; all 8 writes of block 3 dropped; overflow=1.
//       After d_ready=1: 16 bits out, block 1 then block 2, both reversed.
//  4 Block 2 finishes filling on the same cycle block 1 drains its last bit
//    -> d_valid stays 1; block 2 bit 7 appears on the next cycle; no bubble,
//       no drop.
//  5 enable=0 for 1 cycle after 5 of 8 writes, with block 1 mid-drain
//    -> d_valid=0 the next cycle; the partial block is never emitted;
//       the next full block reads out correctly.
//  6 rst asserted asynchronously mid-drain
//    -> d_valid, d_last, overflow=0 immediately; normal operation after release.

Source files
------------

// File: rtl/tbu_lifo_reorder.sv
// Purpose : reverses each BLOCK_LEN-bit block from the traceback unit (emitted
//           newest-first) into forward time order, using two ping-pong LIFO banks.
// Latency : d_valid rises the cycle after the last bit of a block is written into
//           an idle drain bank, with that bit on d_out; sustained 1 bit/cycle.
// Backpressure: d_ready stalls the drain side only. The writer cannot be stalled,
//           so a bit that arrives while both banks are full is dropped and
//           overflow is set. The overflow flag stays set until reset or enable=0.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   enable                          sync run enable; 0 clears all block state
//   d_in, wr_en                     bit stream from the traceback unit
//   d_out, d_valid, d_ready         forward-order output, valid/ready handshake
//   d_last                          marks the final bit of each block
//   overflow                        sticky flag, a write was dropped
module tbu_lifo_reorder #(
   parameter int BLOCK_LEN = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic d_in,
   input  logic wr_en,
   output logic d_out,
   output logic d_valid,
   input  logic d_ready,
   output logic d_last,
   output logic overflow
);

   localparam int PTR_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_LEN - 1);

   // Storage has no reset: contents only matter once a bank is marked full.
   logic [BLOCK_LEN-1:0] r_bank [0:1];

   logic [1:0]       r_full;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_fill_bank;
   logic             r_drain_bank;
   logic             r_overflow;

   logic             w_accept;
   logic             w_drop;
   logic             w_xfer;
   logic             w_fill_done;
   logic             w_drain_done;
   logic [1:0]       w_full_nxt;

   // Writability uses the registered full flag, so a bank freed this cycle
   // only becomes writable on the next one.
   assign w_accept     = enable & wr_en & ~r_full[r_fill_bank];
   assign w_drop       = enable & wr_en &  r_full[r_fill_bank];
   assign w_xfer       = enable & d_valid & d_ready;
   assign w_fill_done  = w_accept & (r_wr_ptr == LAST_PTR);
   assign w_drain_done = w_xfer & (r_rd_ptr == '0);

   // Fill and drain never target the same bank in one cycle (fill needs an
   // empty bank, drain a full one), so both updates can apply independently.
   always_comb begin
      w_full_nxt = r_full;
      if (w_fill_done)  w_full_nxt[r_fill_bank]  = 1'b1;
      if (w_drain_done) w_full_nxt[r_drain_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_bank[r_fill_bank][r_wr_ptr] <= d_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= LAST_PTR;
         r_fill_bank  <= 1'b0;
         r_drain_bank <= 1'b0;
         r_overflow   <= 1'b0;
      end else if (!enable) begin
         r_full       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= LAST_PTR;
         r_fill_bank  <= 1'b0;
         r_drain_bank <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_fill_done) begin
               r_wr_ptr    <= '0;
               r_fill_bank <= ~r_fill_bank;
            end else begin
               r_wr_ptr    <= r_wr_ptr + 1'b1;
            end
         end
         if (w_drop) r_overflow <= 1'b1;
         // Read pointer walks down: last-written bit leaves first.
         if (w_xfer) begin
            if (w_drain_done) begin
               r_rd_ptr     <= LAST_PTR;
               r_drain_bank <= ~r_drain_bank;
            end else begin
               r_rd_ptr     <= r_rd_ptr - 1'b1;
            end
         end
         r_full <= w_full_nxt;
      end
   end

   // Outputs come from registers only. d_out is gated so it reads 0 whenever
   // nothing valid is presented (storage itself is never reset).
   assign d_valid  = r_full[r_drain_bank];
   assign d_out    = d_valid & r_bank[r_drain_bank][r_rd_ptr];
   assign d_last   = d_valid & (r_rd_ptr == '0);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_tbu_lifo_reorder.sv
// Directed bench for tbu_lifo_reorder with BLOCK_LEN=8.
module tb_tbu_lifo_reorder;

   localparam int BL = 8;

   logic clk = 1'b0;
   logic rst, enable, d_in, wr_en, d_ready;
   logic d_out, d_valid, d_last, overflow;

   int n_chk = 0;
   int n_err = 0;

   // Block patterns: bit i is the i-th bit written; output order is bit 7 first.
   logic [7:0] blk_a = 8'h4D;  // writes 1,0,1,1,0,0,1,0 -> out 0,1,0,0,1,1,0,1
   logic [7:0] blk_b = 8'hA6;  // writes 0,1,1,0,0,1,0,1 -> out 1,0,1,0,0,1,1,0
   logic [7:0] blk_c = 8'hB2;  // bitwise complement of blk_a
   logic [7:0] blk_d = 8'h3C;

   always #5 clk = ~clk;

   tbu_lifo_reorder #(.BLOCK_LEN(BL)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .d_in     (d_in),
      .wr_en    (wr_en),
      .d_out    (d_out),
      .d_valid  (d_valid),
      .d_ready  (d_ready),
      .d_last   (d_last),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write a whole block while the drain side is idle.
   task automatic fill_idle(input logic [7:0] bits, input string tag);
      for (int i = 0; i < BL; i++) begin
         wr_en = 1'b1;
         d_in  = bits[i];
         tick();
         if (i < BL - 1) chk({tag, " idle before last write"}, d_valid, 1'b0);
      end
      wr_en = 1'b0;
      d_in  = 1'b0;
      chk({tag, " valid after last write"}, d_valid, 1'b1);
   endtask

   // Unchecked writes of bits[0..n-1].
   task automatic write_bits(input logic [7:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1;
         d_in  = bits[i];
         tick();
      end
      wr_en = 1'b0;
      d_in  = 1'b0;
   endtask

   // Check and transfer outputs k0..k1 of a block (caller holds d_ready=1).
   task automatic drain(input logic [7:0] bits, input int k0, input int k1, input string tag);
      for (int k = k0; k <= k1; k++) begin
         chk({tag, " valid"}, d_valid, 1'b1);
         chk({tag, " data"}, d_out, bits[BL-1-k]);
         chk({tag, " last"}, d_last, (k == BL - 1));
         tick();
      end
   endtask

   // Drain outputs 0..n-1 of b_out while writing b_in[0..n-1].
   task automatic drain_fill(input logic [7:0] b_out, input logic [7:0] b_in,
                             input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         chk({tag, " valid"}, d_valid, 1'b1);
         chk({tag, " data"}, d_out, b_out[BL-1-k]);
         chk({tag, " last"}, d_last, (k == BL - 1));
         wr_en = 1'b1;
         d_in  = b_in[k];
         tick();
      end
      wr_en = 1'b0;
      d_in  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; d_in = 1'b0; wr_en = 1'b0; d_ready = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("reset d_valid", d_valid, 1'b0);
      chk("reset d_last", d_last, 1'b0);
      chk("reset d_out", d_out, 1'b0);
      chk("reset overflow", overflow, 1'b0);
      tick();
      tick();
      rst = 1'b1; enable = 1'b1; d_ready = 1'b1;
      tick();
      chk("post-reset idle", d_valid, 1'b0);

      // 1: single block, always ready
      fill_idle(blk_a, "t1");
      drain(blk_a, 0, 7, "t1 out");
      chk("t1 empty after block", d_valid, 1'b0);
      chk("t1 overflow", overflow, 1'b0);

      // 2: stall for 5 cycles after the 3rd output
      fill_idle(blk_a, "t2");
      drain(blk_a, 0, 2, "t2 out");
      d_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2 stall valid", d_valid, 1'b1);
         chk("t2 stall data", d_out, blk_a[4]);
         chk("t2 stall last", d_last, 1'b0);
         tick();
      end
      d_ready = 1'b1;
      drain(blk_a, 3, 7, "t2 out");
      chk("t2 empty after block", d_valid, 1'b0);
      chk("t2 overflow", overflow, 1'b0);

      // 3: three blocks with the consumer stalled; third is dropped
      d_ready = 1'b0;
      write_bits(blk_a, 8);
      write_bits(blk_b, 8);
      chk("t3 no overflow with both banks full", overflow, 1'b0);
      write_bits(blk_c, 1);
      chk("t3 overflow on first drop", overflow, 1'b1);
      write_bits(blk_c, 7);
      chk("t3 stalled data is block1 bit7", d_out, blk_a[7]);
      d_ready = 1'b1;
      drain(blk_a, 0, 7, "t3 blk1");
      drain(blk_b, 0, 7, "t3 blk2");
      chk("t3 empty after two blocks", d_valid, 1'b0);
      chk("t3 overflow sticky", overflow, 1'b1);

      // 4: block 2 completes fill on the cycle block 1 drains its last bit
      fill_idle(blk_a, "t4");
      drain_fill(blk_a, blk_b, 8, "t4 blk1");
      chk("t4 no bubble", d_valid, 1'b1);
      drain(blk_b, 0, 7, "t4 blk2");
      chk("t4 empty after two blocks", d_valid, 1'b0);
      chk("t4 overflow still sticky", overflow, 1'b1);

      // 5: enable=0 after 5 writes of block 2, block 1 mid-drain
      fill_idle(blk_a, "t5");
      drain_fill(blk_a, blk_b, 5, "t5 blk1");
      enable = 1'b0;
      tick();
      enable = 1'b1;
      chk("t5 valid cleared", d_valid, 1'b0);
      chk("t5 last cleared", d_last, 1'b0);
      chk("t5 data cleared", d_out, 1'b0);
      chk("t5 overflow cleared", overflow, 1'b0);
      tick();
      tick();
      chk("t5 partial never emitted", d_valid, 1'b0);
      fill_idle(blk_d, "t5 next");
      drain(blk_d, 0, 7, "t5 next out");
      chk("t5 empty after block", d_valid, 1'b0);

      // 6: asynchronous reset mid-drain with overflow set
      d_ready = 1'b0;
      write_bits(blk_a, 8);
      write_bits(blk_b, 8);
      write_bits(blk_b, 1);
      chk("t6 overflow before reset", overflow, 1'b1);
      d_ready = 1'b1;
      drain(blk_a, 0, 2, "t6 pre-reset");
      #3 rst = 1'b0;
      #1;
      chk("t6 async valid", d_valid, 1'b0);
      chk("t6 async last", d_last, 1'b0);
      chk("t6 async data", d_out, 1'b0);
      chk("t6 async overflow", overflow, 1'b0);
      #1 rst = 1'b1;
      tick();
      chk("t6 idle after release", d_valid, 1'b0);
      fill_idle(blk_b, "t6 next");
      drain(blk_b, 0, 7, "t6 next out");
      chk("t6 empty after block", d_valid, 1'b0);
      chk("t6 overflow clear", overflow, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
